// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the DSP systolic array: FP32 word, error flags, PE modes,
// DSPFP32 operating-mode words and the FP32 multiply/add datapath functions.
package dsp_sys_arr_pkg;

    typedef logic [31:0] single_float;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic invalid;
    } fp_error;

    typedef enum logic [1:0] {
        PE_MAC = 2'd0,
        PE_MUL = 2'd1,
        PE_ADD = 2'd2
    } pe_mode_t;

    typedef struct packed {
        single_float val;
        fp_error     err;
    } fp_result_t;

    localparam logic [6:0] FPOPMODE_MAC_FIRST = 7'h45;
    localparam logic [6:0] FPOPMODE_MAC_ACC   = 7'h25;
    localparam logic [6:0] FPOPMODE_MUL       = 7'h05;
    localparam logic [6:0] FPOPMODE_ADD       = 7'h1A;

    localparam single_float FP_QNAN = 32'h7FC0_0000;

    // Subnormals flush to zero; results truncate toward zero.
    function automatic fp_result_t fp_mul(input single_float a, input single_float b);
        fp_result_t  r;
        logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0] prod;
        int          e;
        r      = '0;
        sgn    = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r.val         = FP_QNAN;
            r.err.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            r.val = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            r.val = {sgn, 31'd0};
        end else begin
            if (prod[47]) begin
                prod = prod >> 1;
                e    = e + 1;
            end
            if (e >= 255) begin
                r.val          = {sgn, 8'hFF, 23'd0};
                r.err.overflow = 1'b1;
            end else if (e <= 0) begin
                r.val           = {sgn, 31'd0};
                r.err.underflow = 1'b1;
            end else begin
                r.val = {sgn, 8'(e), prod[45:23]};
            end
        end
        return r;
    endfunction

    function automatic fp_result_t fp_add(input single_float a, input single_float b);
        fp_result_t  r;
        single_float big, sml;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [27:0] mb, ms, s;
        int          e, d;
        r      = '0;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            r.val         = FP_QNAN;
            r.err.invalid = 1'b1;
        end else if (a_inf) begin
            r.val = a;
        end else if (b_inf) begin
            r.val = b;
        end else if (a_zero && b_zero) begin
            r.val = {a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            r.val = b;
        end else if (b_zero) begin
            r.val = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            // Hidden one at bit 26, three guard bits below the fraction.
            d  = int'(big[30:23]) - int'(sml[30:23]);
            e  = int'(big[30:23]);
            mb = {2'b01, big[22:0], 3'b000};
            ms = (d > 27) ? 28'd0 : ({2'b01, sml[22:0], 3'b000} >> d);
            s  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
            if (s == 28'd0) begin
                r.val = 32'd0;
            end else begin
                if (s[27]) begin
                    s = s >> 1;
                    e = e + 1;
                end
                for (int i = 0; i < 26; i++) begin
                    if (!s[26]) begin
                        s = s << 1;
                        e = e - 1;
                    end
                end
                if (e >= 255) begin
                    r.val          = {big[31], 8'hFF, 23'd0};
                    r.err.overflow = 1'b1;
                end else if (e <= 0) begin
                    r.val           = {big[31], 31'd0};
                    r.err.underflow = 1'b1;
                end else begin
                    r.val = {big[31], 8'(e), s[25:3]};
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_pe_core.sv
// FP32 arithmetic core: DSPFP32-style MUL/ADD/MAC datapath with a fixed
// LAT-cycle result pipeline and sticky error capture across a MAC vector.
module fp32_pe_core
    import dsp_sys_arr_pkg::*;
#(
    parameter int unsigned LAT = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        in_valid,
    input  logic        in_first,
    input  logic        in_last,
    input  logic [1:0]  in_mode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        core_valid,
    output logic [31:0] core_data,
    output logic [2:0]  core_err
);

    logic [6:0]     opmode_c;
    logic           is_mac_c;
    fp_result_t     prod_c, sum_c, res_c;
    fp_error        err_c;
    single_float    acc_q;
    fp_error        acc_err_q;
    logic [LAT-1:0] vld_q;
    single_float    dat_q [LAT];
    fp_error        err_q [LAT];

    always_comb begin
        case (in_mode)
            PE_MAC:  opmode_c = in_first ? FPOPMODE_MAC_FIRST : FPOPMODE_MAC_ACC;
            PE_ADD:  opmode_c = FPOPMODE_ADD;
            default: opmode_c = FPOPMODE_MUL;
        endcase
    end

    assign is_mac_c = (opmode_c == FPOPMODE_MAC_FIRST) || (opmode_c == FPOPMODE_MAC_ACC);

    // First MAC element starts from the bare product, dropping the old accumulator.
    always_comb begin
        prod_c = fp_mul(in_a, in_b);
        sum_c  = fp_add(acc_q, prod_c.val);
        res_c  = '0;
        err_c  = '0;
        case (opmode_c)
            FPOPMODE_MAC_FIRST, FPOPMODE_MUL: begin
                res_c = prod_c;
                err_c = prod_c.err;
            end
            FPOPMODE_MAC_ACC: begin
                res_c = sum_c;
                err_c = fp_error'(acc_err_q | prod_c.err | sum_c.err);
            end
            FPOPMODE_ADD: begin
                res_c = fp_add(in_a, in_b);
                err_c = res_c.err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q     <= '0;
            acc_err_q <= '0;
        end else if (in_valid && is_mac_c) begin
            acc_q     <= res_c.val;
            acc_err_q <= err_c;
        end
    end

    // Only vector-final MAC elements and every MUL/ADD produce a result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
                err_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid && (!is_mac_c || in_last);
            dat_q[0] <= res_c.val;
            err_q[0] <= err_c;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign core_valid = vld_q[LAT-1];
    assign core_data  = dat_q[LAT-1];
    assign core_err   = err_q[LAT-1];

endmodule

// File: rtl/dsp_pe_stream.sv
// AXI-Stream FP32 processing element: A/B join, credit-gated output FIFO, MAC FSM.
// Define DSP_PE_STATS_EN to add saturating result/error counters.
module dsp_pe_stream
    import dsp_sys_arr_pkg::*;
#(
    parameter int unsigned LAT       = 3,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned DEF_MODE  = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [1:0]  cfg_mode,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tlast,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [31:0] m_axis_result_tdata,
    output logic [2:0]  m_axis_result_tuser,
    output logic        processing
`ifdef DSP_PE_STATS_EN
    ,
    output logic [31:0] stat_results,
    output logic [15:0] stat_errors
`endif
);

    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {ST_IDLE, ST_ACC} mac_state_t;

    mac_state_t       state_q, state_d;
    pe_mode_t         mode_q;
    logic             run_q;
    logic [CNT_W-1:0] inflight_q, fifo_cnt_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    single_float      fifo_data_q [OUT_DEPTH];
    fp_error          fifo_err_q  [OUT_DEPTH];
    logic             credit_ok_c, fire_c, issue_c, push_c, pop_c;
    logic             core_valid;
    logic [31:0]      core_data;
    logic [2:0]       core_err;

    // Every result-producing fire reserves a FIFO slot, so a core result always fits.
    assign credit_ok_c = (SUM_W'(fifo_cnt_q) + SUM_W'(inflight_q)) < SUM_W'(OUT_DEPTH);
    assign fire_c      = run_q && s_axis_a_tvalid && s_axis_b_tvalid && credit_ok_c;
    assign issue_c     = fire_c && ((mode_q != PE_MAC) || s_axis_a_tlast);
    assign push_c      = core_valid;
    assign pop_c       = m_axis_result_tvalid && m_axis_result_tready;

    assign s_axis_a_tready = fire_c;
    assign s_axis_b_tready = fire_c;
    assign cfg_ready       = (state_q == ST_IDLE) && (inflight_q == '0);
    assign processing      = (state_q == ST_ACC) || (inflight_q != '0) || (fifo_cnt_q != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fire_c && (mode_q == PE_MAC)) begin
            state_d = s_axis_a_tlast ? ST_IDLE : ST_ACC;
        end
    end

    // run_q keeps the input ports closed for the first cycle out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q      <= 1'b0;
            mode_q     <= pe_mode_t'(2'(DEF_MODE));
            inflight_q <= '0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= inflight_q + CNT_W'(issue_c) - CNT_W'(push_c);
            if (cfg_valid && cfg_ready) begin
                mode_q <= (cfg_mode == 2'd3) ? PE_MUL : pe_mode_t'(cfg_mode);
            end
        end
    end

    fp32_pe_core #(
        .LAT (LAT)
    ) u_core (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_valid   (fire_c),
        .in_first   (state_q == ST_IDLE),
        .in_last    (s_axis_a_tlast),
        .in_mode    (mode_q),
        .in_a       (s_axis_a_tdata),
        .in_b       (s_axis_b_tdata),
        .core_valid (core_valid),
        .core_data  (core_data),
        .core_err   (core_err)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_err_q[i]  <= '0;
            end
        end else begin
            if (push_c) begin
                fifo_data_q[wr_ptr_q] <= core_data;
                fifo_err_q[wr_ptr_q]  <= fp_error'(core_err);
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    assign m_axis_result_tvalid = (fifo_cnt_q != '0);
    assign m_axis_result_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_result_tuser  = fifo_err_q[rd_ptr_q];

`ifdef DSP_PE_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_results <= '0;
            stat_errors  <= '0;
        end else if (pop_c) begin
            if (stat_results != '1) stat_results <= stat_results + 32'd1;
            if ((m_axis_result_tuser != '0) && (stat_errors != '1)) begin
                stat_errors <= stat_errors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_pe_stream.sv
// Directed self-checking bench for dsp_pe_stream (default parameters).
module tb_dsp_pe_stream;

    localparam int unsigned LAT       = 3;
    localparam int unsigned OUT_DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  cfg_mode;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
    logic [31:0] s_axis_a_tdata;
    logic        s_axis_b_tvalid, s_axis_b_tready;
    logic [31:0] s_axis_b_tdata;
    logic        m_axis_result_tvalid, m_axis_result_tready;
    logic [31:0] m_axis_result_tdata;
    logic [2:0]  m_axis_result_tuser;
    logic        processing;
`ifdef DSP_PE_STATS_EN
    logic [31:0] stat_results;
    logic [15:0] stat_errors;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    dsp_pe_stream #(
        .LAT       (LAT),
        .OUT_DEPTH (OUT_DEPTH),
        .DEF_MODE  (0)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .cfg_mode             (cfg_mode),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .s_axis_a_tvalid      (s_axis_a_tvalid),
        .s_axis_a_tready      (s_axis_a_tready),
        .s_axis_a_tdata       (s_axis_a_tdata),
        .s_axis_a_tlast       (s_axis_a_tlast),
        .s_axis_b_tvalid      (s_axis_b_tvalid),
        .s_axis_b_tready      (s_axis_b_tready),
        .s_axis_b_tdata       (s_axis_b_tdata),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tready (m_axis_result_tready),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .m_axis_result_tuser  (m_axis_result_tuser),
        .processing           (processing)
`ifdef DSP_PE_STATS_EN
        ,
        .stat_results         (stat_results),
        .stat_errors          (stat_errors)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        s_axis_a_tdata  = a;
        s_axis_b_tdata  = b;
        s_axis_a_tlast  = last;
        #1;
        while (!s_axis_a_tready && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("send_ready", 32'(s_axis_a_tready && s_axis_b_tready), 32'd1);
        @(negedge aclk);
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        s_axis_a_tlast  = 1'b0;
    endtask

    task automatic get(input string tag, input logic [31:0] exp_d, input logic [2:0] exp_u);
        int n = 0;
        while (!m_axis_result_tvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_valid"}, 32'(m_axis_result_tvalid), 32'd1);
        check({tag, "_data"}, m_axis_result_tdata, exp_d);
        check({tag, "_user"}, 32'(m_axis_result_tuser), 32'(exp_u));
        m_axis_result_tready = 1'b1;
        @(negedge aclk);
        m_axis_result_tready = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_mode  = m;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int acc_n = 0;
        int rcv_n = 0;
        aresetn              = 1'b0;
        cfg_mode             = 2'd0;
        cfg_valid            = 1'b0;
        s_axis_a_tvalid      = 1'b1;
        s_axis_b_tvalid      = 1'b1;
        s_axis_a_tdata       = 32'h3F80_0000;
        s_axis_b_tdata       = 32'h3F80_0000;
        s_axis_a_tlast       = 1'b0;
        m_axis_result_tready = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset state, with both operand ports offering data.
        check("rst_a_tready", 32'(s_axis_a_tready), 32'd0);
        check("rst_b_tready", 32'(s_axis_b_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_result_tvalid), 32'd0);
        check("rst_tdata", m_axis_result_tdata, 32'd0);
        check("rst_tuser", 32'(m_axis_result_tuser), 32'd0);
        check("rst_processing", 32'(processing), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Only one port valid: the join must not accept it.
        s_axis_a_tvalid = 1'b1;
        #1;
        check("single_valid_tready", 32'(s_axis_a_tready), 32'd0);
        @(negedge aclk);
        s_axis_a_tvalid = 1'b0;

        // MUL 1.0*2.0 with exact LAT+1 latency.
        set_mode(2'd1);
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        check("mul_processing", 32'(processing), 32'd1);
        repeat (LAT - 1) @(negedge aclk);
        check("mul_early", 32'(m_axis_result_tvalid), 32'd0);
        @(negedge aclk);
        check("mul_latency", 32'(m_axis_result_tvalid), 32'd1);
        get("mul", 32'h4000_0000, 3'b000);

        // ADD 1.0+2.0.
        set_mode(2'd2);
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        get("add", 32'h4040_0000, 3'b000);

        // MAC [1,2].[2,3] = 8, then single-element 2*2 = 4.
        set_mode(2'd0);
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        check("mac_acc_cfg_ready", 32'(cfg_ready), 32'd0);
        repeat (LAT + 2) @(negedge aclk);
        check("mac_partial_silent", 32'(m_axis_result_tvalid), 32'd0);
        send(32'h4000_0000, 32'h4040_0000, 1'b1);
        get("mac2", 32'h4100_0000, 3'b000);
        send(32'h4000_0000, 32'h4000_0000, 1'b1);
        get("mac1", 32'h4080_0000, 3'b000);
        repeat (LAT + 2) @(negedge aclk);
        check("mac_one_result", 32'(m_axis_result_tvalid), 32'd0);

        // MAC overflow: 2^127*2 then +1*1, overflow flag sticks to the vector result.
        send(32'h7F00_0000, 32'h4000_0000, 1'b0);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        get("mac_ovf", 32'h7F80_0000, 3'b100);

        // Reserved mode 3 behaves as MUL: 3.0*2.0.
        set_mode(2'd3);
        send(32'h4040_0000, 32'h4000_0000, 1'b0);
        get("rsv_mul", 32'h40C0_0000, 3'b000);

        // Backpressure: 10 MUL ops of 1.5*2^k times 2.0 with the result port stalled.
        s_axis_a_tvalid = 1'b1;
        s_axis_b_tvalid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_axis_a_tdata = 32'h3FC0_0000 + (32'(acc_n) << 23);
            s_axis_b_tdata = 32'h4000_0000;
            #1;
            if (s_axis_a_tready) acc_n++;
            @(negedge aclk);
        end
        #1;
        check("bp_accepted", 32'(acc_n), 32'(OUT_DEPTH));
        check("bp_tready_low", 32'(s_axis_a_tready), 32'd0);
        m_axis_result_tready = 1'b1;
        for (int cyc = 0; cyc < 100 && rcv_n < 10; cyc++) begin
            s_axis_a_tvalid = (acc_n < 10);
            s_axis_b_tvalid = (acc_n < 10);
            s_axis_a_tdata  = 32'h3FC0_0000 + (32'(acc_n) << 23);
            #1;
            if (s_axis_a_tvalid && s_axis_a_tready) acc_n++;
            if (m_axis_result_tvalid) begin
                check("bp_data", m_axis_result_tdata, 32'h3FC0_0000 + (32'(rcv_n + 1) << 23));
                rcv_n++;
            end
            @(negedge aclk);
        end
        s_axis_a_tvalid      = 1'b0;
        s_axis_b_tvalid      = 1'b0;
        m_axis_result_tready = 1'b0;
        check("bp_total_in", 32'(acc_n), 32'd10);
        check("bp_total_out", 32'(rcv_n), 32'd10);

        // cfg_valid during ACC is dropped: 1*1 + 2*2 stays a MAC result of 5.0.
        set_mode(2'd0);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        check("acc_cfg_ready_low", 32'(cfg_ready), 32'd0);
        cfg_mode  = 2'd1;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
        send(32'h4000_0000, 32'h4000_0000, 1'b1);
        get("mac_cfg_ignored", 32'h40A0_0000, 3'b000);

        // Reset in the middle of a vector discards the partial sum.
        send(32'h4040_0000, 32'h4040_0000, 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_processing", 32'(processing), 32'd0);
        aresetn = 1'b1;
        repeat (LAT + 2) @(negedge aclk);
        check("midrst_no_stale", 32'(m_axis_result_tvalid), 32'd0);

        // Mode is MAC again after reset: 2*2 (no result) then 1*1 last gives 5.0.
        send(32'h4000_0000, 32'h4000_0000, 1'b0);
        repeat (LAT + 2) @(negedge aclk);
        check("def_mac_silent", 32'(m_axis_result_tvalid), 32'd0);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        get("def_mac", 32'h40A0_0000, 3'b000);

        set_mode(2'd1);
        send(32'h4040_0000, 32'h4000_0000, 1'b0);
        get("post_rst_mul", 32'h40C0_0000, 3'b000);
        repeat (LAT + 2) @(negedge aclk);
        check("final_empty", 32'(m_axis_result_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_pe_stream.md
Name: dsp_pe_stream

Overview:
- Next-generation FP32 processing element for the DSP systolic array.
- Joins two AXI-Stream operand ports (A, B) and executes MUL, ADD or MAC, selectable at run time.
- MAC supports vector boundaries via A tlast. A credit-gated output FIFO removes the single-slot blocking limit.
- Sits between array edge buffers and neighbouring PEs; arithmetic lives in sub-module fp32_pe_core, a DSPFP32 wrapper.

Parameters:
- LAT, 3, fixed fp32_pe_core latency in cycles, valid range 1-6.
- OUT_DEPTH, 4, output FIFO depth; power of 2, at least 2.
- DEF_MODE, 0, mode after reset: 0 MAC, 1 MUL, 2 ADD.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cfg_mode  in  2  requested mode; 3 is reserved and treated as MUL
- cfg_valid  in  1  mode update strobe
- cfg_ready  out  1  high when the PE is idle, so the mode may change
- s_axis_a_tvalid / s_axis_a_tready  in/out  1  A handshake
- s_axis_a_tdata  in  32  single_float
- s_axis_a_tlast  in  1  last element of a MAC vector
- s_axis_b_tvalid / s_axis_b_tready  in/out  1  B handshake
- s_axis_b_tdata  in  32  single_float
- m_axis_result_tvalid / m_axis_result_tready  out/in  1  result handshake
- m_axis_result_tdata  out  32  single_float
- m_axis_result_tuser  out  error  overflow, underflow, invalid, taken as sticky OR over the vector in MAC
- processing  out  1  pipeline or FIFO non-empty

Behaviour:
- Reset values of all outputs: tready 0, tvalid 0, tdata 0, tuser 0, processing 0, cfg_ready 1. Mode resets to DEF_MODE. FIFO, in-flight counter and accumulation state are cleared.
- Join: an operation fires when both A and B are valid and credit is available. On fire, both tready assert in the same cycle; no operand is ever held alone.
  - s_axis_a_tready = s_axis_b_tready = both tvalid AND credit_ok.
  - Consequence: a single valid port sees tready=0.
- Credit: credit_ok = (fifo_count + inflight_results) < OUT_DEPTH.
  - Increment inflight_results on fire, except for non-last MAC elements.
  - Decrement inflight_results on core result valid.
  - No result is ever dropped; a result with no FIFO room cannot occur.
- Core: fire issues a, b and first (start of vector) to fp32_pe_core.
  - Results appear exactly LAT cycles later with core_valid.
  - In MAC, core_valid is asserted only for the tlast element.
- MAC state machine, states IDLE and ACC:
  - IDLE: on fire, first=1 and the accumulator is cleared. If tlast, stay IDLE (single-element vector); else go to ACC.
  - ACC: on fire, first=0. If tlast, go to IDLE.
- MUL/ADD: every fire produces one result. tlast is ignored. ADD computes a+b using DSPFP32 C-path selection.
- tuser in MAC is the OR of the per-element flags from first through last, cleared at vector start.
- Mode change:
  - cfg_ready = IDLE state AND no in-flight operations. The FIFO may be non-empty.
  - cfg_valid while cfg_ready=0 is ignored; the update is not queued.
- FIFO:
  - The head drives m_axis_result_t*.
  - Pop on tvalid & tready. A push and pop in the same cycle is legal, including when the FIFO is full.
  - Pointers are log2(OUT_DEPTH) bits and wrap.
- Throughput: one fire per cycle while credit allows. Minimum input-to-output latency is LAT+1, because FIFO output is registered.
- Reset mid-vector: the accumulator is discarded and no partial result is emitted.

Optional Feature:
- Macro DSP_PE_STATS_EN.
- Defined: adds ports stat_results (out, 32) and stat_errors (out, 16). Both are saturating counters of popped results and of popped results with tuser non-zero. Both clear on reset.
- Undefined: neither port nor counter exists.

Decomposition:
- dsp_sys_arr_pkg gains:
  - a pe_mode_t enum (PE_MAC, PE_MUL, PE_ADD);
  - FPOPMODE constants for MAC-first, MAC-accumulate, MUL and ADD;
  - fp_error with an invalid field added to the existing error type.
- Existing single_float is reused.
- Sub-module fp32_pe_core: DSPFP32 instance plus a LAT-deep valid/first/last shift register and flag capture. The stream wrapper holds the join, credit, FSM and FIFO.

Test Plan:
- MUL: A=0x3F800000 (1.0), B=0x40000000 (2.0) -> result 0x40000000 after LAT+1 cycles, tuser 0.
- ADD: A=0x3F800000, B=0x40000000 -> result 0x40400000 (3.0).
- MAC vector [1.0, 2.0]·[2.0, 3.0] with tlast on the 2nd element -> exactly one result 0x41000000 (8.0). Then a single-element vector 2.0·2.0 with tlast -> 0x40800000, with no carry-over.
- Backpressure: hold m_axis_result_tready=0 and stream 10 MUL ops -> exactly OUT_DEPTH accepted, then tready drops. Release tready -> all 10 results arrive in order, none lost.
- Overflow: MAC of 0x7F000000·0x40000000 followed by 1.0·1.0 with tlast -> tuser.overflow=1 on the vector result.
- Reset asserted mid-vector, then a new MUL 3.0·2.0 -> 0x40C00000 and no stale MAC result. cfg_valid during ACC is ignored.
